uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
- UART receive framer, directly downstream of the baud-rate tick generator in the uart block.
- Samples the serial rx line once per generator rx tick (mid-bit) and drives the generator's rx enable.
- Assembles start/data/parity/stop, then presents each byte with status flags through a single-entry valid/ready holding register to the bus-side register file.

Parameters:
DATA_BITS, 8, data bits per frame (5..8), LSB first
PARITY_EN, 0, 1 = one parity bit follows data
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low; all state cleared while low
rx  in  1  serial line, asynchronous to clock, idle high
rx_tick  in  1  single-cycle sample pulse from baud generator; first pulse lands at mid start bit, then one per bit period
rx_tick_en  out  1  enable to baud generator; low restarts its counter
rx_data  out  DATA_BITS  received byte
rx_valid  out  1  holding register full
rx_ready  in  1  consumer accepts; transfer when rx_valid && rx_ready
rx_frame_err  out  1  stop bit sampled low for the held byte
rx_parity_err  out  1  parity mismatch for the held byte
rx_overrun  out  1  sticky: completed frame dropped because holding register full
overrun_clr  in  1  clears rx_overrun
rx_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: rx_tick_en=0, rx_data=0, rx_valid=0, rx_frame_err=0, rx_parity_err=0, rx_overrun=0, rx_busy=0, state=IDLE, both synchronizer flops=1.
- Reset asserted mid-frame aborts the frame immediately; no partial byte is delivered.
- rx passes through a 2-flop synchronizer; rx_s is its output, rx_s_d is rx_s delayed one cycle. All decisions use rx_s.
- FSM states: IDLE, START, DATA, PARITY, STOP. rx_tick_en = (state != IDLE), registered via state. rx_tick is ignored in IDLE.
- IDLE: if rx_s_d==1 && rx_s==0 (falling edge), go to START. rx_tick_en rises the next cycle.
- START: on rx_tick, if rx_s==0 go to DATA with bit_cnt=0. If rx_s==1 (glitch/false start), go to IDLE; rx_tick_en is low for at least one cycle.
- DATA: on each rx_tick, shift rx_s into bit position bit_cnt (LSB first) and increment bit_cnt. On the tick where bit_cnt==DATA_BITS-1, go to PARITY if PARITY_EN, else STOP.
- PARITY: on rx_tick, perr = rx_s XOR (^shift) XOR PARITY_ODD; go to STOP. perr is 0 when PARITY_EN=0.
- STOP: on rx_tick, ferr = ~rx_s; complete the frame; go to IDLE.
- A low stop bit (break) returns the FSM to IDLE. A new start requires a fresh 1->0 edge on rx_s.
- Frame completion, registered, visible the cycle after the stop tick:
  - If !rx_valid, or rx_valid && rx_ready in the same cycle: load rx_data, rx_frame_err=ferr, rx_parity_err=perr; rx_valid=1.
  - Else: holding register unchanged; rx_overrun<=1; the frame is discarded.
- rx_valid clears the cycle after rx_valid && rx_ready with no completion in that cycle. rx_data and the error flags hold their values until the next load.
- rx_overrun: set has priority over overrun_clr in the same cycle; otherwise overrun_clr clears it.
- rx_busy = (state != IDLE).
- Latency from stop-bit tick to rx_valid high: 1 cycle.
- bit_cnt is ceil(log2(DATA_BITS)) bits wide and is never compared beyond DATA_BITS-1.

Test Plan:
- 8N1 byte 0xA5, bench tick model period 16 cycles, first tick 8 cycles after edge, rx_ready held 0 -> rx_valid=1, rx_data=0xA5, both error flags 0, rx_busy low one cycle after the stop tick, rx_tick_en low in IDLE.
- 3-cycle low glitch on rx, rx high at first tick -> FSM returns to IDLE, rx_valid stays 0, rx_tick_en drops for at least 1 cycle; a following valid 0x3C frame is received correctly.
- PARITY_EN=1, PARITY_ODD=0, byte 0x07 sent with parity bit 0 -> rx_parity_err=1, rx_data=0x07; repeat with parity bit 1 -> rx_parity_err=0.
- Stop bit driven low for byte 0x55 -> rx_frame_err=1, rx_data=0x55; next frame is not accepted until rx returns high and falls again.
- Two frames 0x11 then 0x22 with rx_ready=0 -> rx_data stays 0x11 and rx_overrun=1. Pulse overrun_clr -> rx_overrun=0. Repeat with rx_ready=1 in the completion cycle -> rx_data=0x22, rx_valid stays 1, no overrun.
- Assert reset low during DATA bit 4 -> all outputs at reset values immediately. After release, a full frame 0xF0 is received correctly.

Source files
------------

// File: rtl/uart_rx_frame.sv
// UART receive framer: samples the synchronized rx line on each baud-generator tick,
// assembles start/data/parity/stop and hands each byte over through a one-entry holding register.
module uart_rx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rx_tick,
  output logic                 rx_tick_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  input  logic                 overrun_clr,
  output logic                 rx_busy
);

  localparam int   CNT_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic ODD_BIT = (PARITY_ODD != 0);
  localparam logic HAS_PAR = (PARITY_EN != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic                 r_sync1;
  logic                 r_rx_s;
  logic                 r_rx_s_d;
  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr_q;
  logic                 r_perr_q;
  logic                 r_overrun;

  logic w_fall;
  logic w_done;
  logic w_load;
  logic w_drop;

  assign w_fall = r_rx_s_d & ~r_rx_s;
  assign w_done = (r_state == S_STOP) && rx_tick;
  assign w_load = w_done && (!r_valid || rx_ready);
  assign w_drop = w_done && r_valid && !rx_ready;

  // Synchronizer and edge-detect flops reset to the idle-high line level so that
  // releasing reset never looks like a start-bit edge.
  // NOTE: every sequential block uses non-blocking assignments so all flops update from
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1  <= 1'b1;
      r_rx_s   <= 1'b1;
      r_rx_s_d <= 1'b1;
    end else begin
      r_sync1  <= rx;
      r_rx_s   <= r_sync1;
      r_rx_s_d <= r_rx_s;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_perr    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fall) r_state <= S_START;
        end
        S_START: begin
          if (rx_tick) begin
            if (!r_rx_s) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
              r_perr    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (rx_tick) begin
            r_shift[r_bit_cnt] <= r_rx_s;
            r_bit_cnt          <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == CNT_W'(DATA_BITS - 1))
              r_state <= HAS_PAR ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (rx_tick) begin
            r_perr  <= r_rx_s ^ (^r_shift) ^ ODD_BIT;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (rx_tick) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Holding register: a completing frame may load in the same cycle the old byte is taken.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr_q  <= 1'b0;
      r_perr_q  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_load) begin
        r_data   <= r_shift;
        r_ferr_q <= ~r_rx_s;
        r_perr_q <= r_perr;
        r_valid  <= 1'b1;
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end

      if (w_drop)           r_overrun <= 1'b1;
      else if (overrun_clr) r_overrun <= 1'b0;
    end
  end

  assign rx_tick_en    = (r_state != S_IDLE);
  assign rx_busy       = (r_state != S_IDLE);
  assign rx_data       = r_data;
  assign rx_valid      = r_valid;
  assign rx_frame_err  = r_ferr_q;
  assign rx_parity_err = r_perr_q;
  assign rx_overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: an 8N1 instance and an 8E1 instance, each fed by a
// bench tick model (16-cycle bit period, first tick 8 cycles after the start edge).
module tb_uart_rx_frame;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_ready = 1'b0;
  logic       overrun_clr = 1'b0;

  logic       n_rx = 1'b1, n_tick = 1'b0;
  logic       n_tick_en, n_valid, n_ferr, n_perr, n_ovr, n_busy;
  logic [7:0] n_data;

  logic       p_rx = 1'b1, p_tick = 1'b0;
  logic       p_tick_en, p_valid, p_ferr, p_perr, p_ovr, p_busy;
  logic [7:0] p_data;

  int vecs = 0;
  int errs = 0;

  always #5 clock = ~clock;

  uart_rx_frame #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_n (
    .clock(clock), .reset(reset_n), .rx(n_rx), .rx_tick(n_tick), .rx_tick_en(n_tick_en),
    .rx_data(n_data), .rx_valid(n_valid), .rx_ready(rx_ready), .rx_frame_err(n_ferr),
    .rx_parity_err(n_perr), .rx_overrun(n_ovr), .overrun_clr(overrun_clr), .rx_busy(n_busy)
  );

  uart_rx_frame #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_p (
    .clock(clock), .reset(reset_n), .rx(p_rx), .rx_tick(p_tick), .rx_tick_en(p_tick_en),
    .rx_data(p_data), .rx_valid(p_valid), .rx_ready(rx_ready), .rx_frame_err(p_ferr),
    .rx_parity_err(p_perr), .rx_overrun(p_ovr), .overrun_clr(overrun_clr), .rx_busy(p_busy)
  );

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_line(input int dut, input logic v);
    if (dut == 0) n_rx = v; else p_rx = v;
  endtask

  task automatic set_tick(input int dut, input logic v);
    if (dut == 0) n_tick = v; else p_tick = v;
  endtask

  // Drives one frame; returns one cycle after the last tick issued (stop tick, or the
  // max_ticks-th tick when aborting early). rdy_stop raises rx_ready with the stop tick.
  task automatic send_frame(input int dut, input logic [7:0] data, input bit par_en,
                            input logic par_bit, input logic stop_bit, input bit rdy_stop,
                            input int max_ticks);
    logic bits [0:10];
    int   n;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    n = 9;
    if (par_en) begin bits[n] = par_bit; n++; end
    bits[n] = stop_bit;
    n++;
    for (int k = 0; k < n; k++) begin
      set_line(dut, bits[k]);
      repeat (7) cyc();
      set_tick(dut, 1'b1);
      if (rdy_stop && k == n - 1) rx_ready = 1'b1;
      cyc();
      set_tick(dut, 1'b0);
      rx_ready = 1'b0;
      if (k + 1 == max_ticks || k == n - 1) return;
      repeat (8) cyc();
    end
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    cyc();
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) cyc();
    vecs++; if (n_tick_en !== 1'b0) begin errs++; $display("FAIL reset_tick_en got %b exp 0", n_tick_en); end
    vecs++; if (n_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b exp 0", n_valid); end
    vecs++; if (n_data !== 8'h00) begin errs++; $display("FAIL reset_data got %h exp 00", n_data); end
    vecs++; if (n_busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b exp 0", n_busy); end
    vecs++; if ({n_ferr, n_perr, n_ovr} !== 3'b000) begin errs++; $display("FAIL reset_flags got %b exp 000", {n_ferr, n_perr, n_ovr}); end
    reset_n = 1'b1;
    repeat (4) cyc();
    vecs++; if (n_busy !== 1'b0) begin errs++; $display("FAIL reset_release_busy got %b exp 0", n_busy); end
  endtask

  task automatic test_basic_8n1();
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 99);
    vecs++; if (n_valid !== 1'b1) begin errs++; $display("FAIL basic_valid got %b exp 1", n_valid); end
    vecs++; if (n_data !== 8'hA5) begin errs++; $display("FAIL basic_data got %h exp a5", n_data); end
    vecs++; if ({n_ferr, n_perr} !== 2'b00) begin errs++; $display("FAIL basic_errs got %b exp 00", {n_ferr, n_perr}); end
    vecs++; if (n_busy !== 1'b0) begin errs++; $display("FAIL basic_busy got %b exp 0", n_busy); end
    vecs++; if (n_tick_en !== 1'b0) begin errs++; $display("FAIL basic_tick_en got %b exp 0", n_tick_en); end
    repeat (4) cyc();
    vecs++; if (n_valid !== 1'b1) begin errs++; $display("FAIL basic_hold got %b exp 1", n_valid); end
    consume();
    vecs++; if (n_valid !== 1'b0) begin errs++; $display("FAIL basic_consume got %b exp 0", n_valid); end
  endtask

  task automatic test_glitch();
    n_rx = 1'b0;
    repeat (3) cyc();
    n_rx = 1'b1;
    repeat (4) cyc();
    vecs++; if (n_tick_en !== 1'b1) begin errs++; $display("FAIL glitch_start_tick_en got %b exp 1", n_tick_en); end
    n_tick = 1'b1;
    cyc();
    n_tick = 1'b0;
    vecs++; if (n_tick_en !== 1'b0) begin errs++; $display("FAIL glitch_tick_en_drop got %b exp 0", n_tick_en); end
    vecs++; if (n_busy !== 1'b0) begin errs++; $display("FAIL glitch_busy got %b exp 0", n_busy); end
    repeat (10) cyc();
    vecs++; if (n_valid !== 1'b0) begin errs++; $display("FAIL glitch_valid got %b exp 0", n_valid); end
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 99);
    vecs++; if (n_valid !== 1'b1) begin errs++; $display("FAIL glitch_next_valid got %b exp 1", n_valid); end
    vecs++; if (n_data !== 8'h3C) begin errs++; $display("FAIL glitch_next_data got %h exp 3c", n_data); end
    consume();
  endtask

  task automatic test_parity();
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 99);
    vecs++; if (p_valid !== 1'b1) begin errs++; $display("FAIL par_bad_valid got %b exp 1", p_valid); end
    vecs++; if (p_data !== 8'h07) begin errs++; $display("FAIL par_bad_data got %h exp 07", p_data); end
    vecs++; if (p_perr !== 1'b1) begin errs++; $display("FAIL par_bad_perr got %b exp 1", p_perr); end
    vecs++; if (p_ferr !== 1'b0) begin errs++; $display("FAIL par_bad_ferr got %b exp 0", p_ferr); end
    consume();
    repeat (5) cyc();
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 99);
    vecs++; if (p_data !== 8'h07) begin errs++; $display("FAIL par_good_data got %h exp 07", p_data); end
    vecs++; if (p_perr !== 1'b0) begin errs++; $display("FAIL par_good_perr got %b exp 0", p_perr); end
    vecs++; if (p_valid !== 1'b1) begin errs++; $display("FAIL par_good_valid got %b exp 1", p_valid); end
    consume();
  endtask

  task automatic test_break();
    logic busy_seen;
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 99);
    vecs++; if (n_frame_chk(1'b1) !== 1'b1) begin errs++; $display("FAIL break_ferr got %b exp 1", n_ferr); end
    vecs++; if (n_data !== 8'h55) begin errs++; $display("FAIL break_data got %h exp 55", n_data); end
    vecs++; if (n_busy !== 1'b0) begin errs++; $display("FAIL break_busy got %b exp 0", n_busy); end
    consume();
    busy_seen = 1'b0;
    for (int t = 0; t < 3; t++) begin
      repeat (15) cyc();
      n_tick = 1'b1;
      cyc();
      n_tick = 1'b0;
      busy_seen = busy_seen | n_busy;
    end
    vecs++; if (busy_seen !== 1'b0) begin errs++; $display("FAIL break_no_restart got %b exp 0", busy_seen); end
    vecs++; if (n_valid !== 1'b0) begin errs++; $display("FAIL break_no_frame got %b exp 0", n_valid); end
    n_rx = 1'b1;
    repeat (20) cyc();
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 99);
    vecs++; if (n_data !== 8'h5A) begin errs++; $display("FAIL break_next_data got %h exp 5a", n_data); end
    vecs++; if (n_ferr !== 1'b0) begin errs++; $display("FAIL break_next_ferr got %b exp 0", n_ferr); end
    consume();
  endtask

  function automatic logic n_frame_chk(input logic dummy);
    return n_ferr & dummy;
  endfunction

  task automatic test_overrun();
    repeat (5) cyc();
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 99);
    repeat (5) cyc();
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 99);
    vecs++; if (n_data !== 8'h11) begin errs++; $display("FAIL ovr_data got %h exp 11", n_data); end
    vecs++; if (n_ovr !== 1'b1) begin errs++; $display("FAIL ovr_flag got %b exp 1", n_ovr); end
    vecs++; if (n_valid !== 1'b1) begin errs++; $display("FAIL ovr_valid got %b exp 1", n_valid); end
    repeat (3) cyc();
    vecs++; if (n_ovr !== 1'b1) begin errs++; $display("FAIL ovr_sticky got %b exp 1", n_ovr); end
    overrun_clr = 1'b1;
    cyc();
    overrun_clr = 1'b0;
    vecs++; if (n_ovr !== 1'b0) begin errs++; $display("FAIL ovr_clear got %b exp 0", n_ovr); end
    repeat (5) cyc();
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 99);
    vecs++; if (n_data !== 8'h22) begin errs++; $display("FAIL ovr_swap_data got %h exp 22", n_data); end
    vecs++; if (n_valid !== 1'b1) begin errs++; $display("FAIL ovr_swap_valid got %b exp 1", n_valid); end
    vecs++; if (n_ovr !== 1'b0) begin errs++; $display("FAIL ovr_swap_flag got %b exp 0", n_ovr); end
  endtask

  task automatic test_reset_midframe();
    repeat (5) cyc();
    send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 5);
    repeat (6) cyc();
    vecs++; if (n_busy !== 1'b1) begin errs++; $display("FAIL mid_busy_before got %b exp 1", n_busy); end
    reset_n = 1'b0;
    #1;
    vecs++; if (n_tick_en !== 1'b0) begin errs++; $display("FAIL mid_tick_en got %b exp 0", n_tick_en); end
    vecs++; if (n_busy !== 1'b0) begin errs++; $display("FAIL mid_busy got %b exp 0", n_busy); end
    vecs++; if (n_valid !== 1'b0) begin errs++; $display("FAIL mid_valid got %b exp 0", n_valid); end
    vecs++; if (n_data !== 8'h00) begin errs++; $display("FAIL mid_data got %h exp 00", n_data); end
    vecs++; if ({n_ferr, n_perr, n_ovr} !== 3'b000) begin errs++; $display("FAIL mid_flags got %b exp 000", {n_ferr, n_perr, n_ovr}); end
    n_rx = 1'b1;
    repeat (3) cyc();
    reset_n = 1'b1;
    repeat (10) cyc();
    vecs++; if (n_valid !== 1'b0) begin errs++; $display("FAIL mid_no_partial got %b exp 0", n_valid); end
    send_frame(0, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 99);
    vecs++; if (n_valid !== 1'b1) begin errs++; $display("FAIL mid_next_valid got %b exp 1", n_valid); end
    vecs++; if (n_data !== 8'hF0) begin errs++; $display("FAIL mid_next_data got %h exp f0", n_data); end
  endtask

  initial begin
    cyc();
    test_reset();
    test_basic_8n1();
    test_glitch();
    test_parity();
    test_break();
    test_overrun();
    test_reset_midframe();
    repeat (5) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
